// File: rtl/reg_cmd_ctrl.sv
// reg_cmd_ctrl
// Decodes UART command bytes into register-file accesses and returns read
// data to a TX FIFO.
//   0xAA, addr, data : register write
//   0xBB, addr       : register read, result pushed to the TX FIFO
//
// Ports
//   CLK, RST               clock, async active-low reset
//   RX_P_DATA, RX_D_VLD    received byte and its one-cycle strobe
//   Address, WrData        register address / write data (held between strobes)
//   WrEn, RdEn             one-cycle register write / read strobes
//   RdData, RdData_VLD     register read data and its valid
//   FIFO_FULL              TX FIFO back-pressure
//   TX_P_DATA, TX_D_VLD    byte and one-cycle push strobe to the TX FIFO
//   BUSY                   high while the FSM is not in IDLE
//   CMD_ERR                one-cycle pulse on a protocol error or read timeout
//
// state   | meaning
// --------+----------------------------------------------------
// IDLE    | waiting for a command byte
// WR_ADDR | write command seen, waiting for address byte
// WR_DATA | write address latched, waiting for data byte
// RD_ADDR | read command seen, waiting for address byte
// RD_WAIT | read strobe issued, waiting for RdData_VLD or timeout
// TX_SEND | read data held, waiting for room in the TX FIFO
module reg_cmd_ctrl #(
  parameter int WIDTH      = 8,
  parameter int ADDR       = 4,
  parameter int RD_TIMEOUT = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] RX_P_DATA,
  input  logic             RX_D_VLD,
  output logic [ADDR-1:0]  Address,
  output logic [WIDTH-1:0] WrData,
  output logic             WrEn,
  output logic             RdEn,
  input  logic [WIDTH-1:0] RdData,
  input  logic             RdData_VLD,
  input  logic             FIFO_FULL,
  output logic [WIDTH-1:0] TX_P_DATA,
  output logic             TX_D_VLD,
  output logic             BUSY,
  output logic             CMD_ERR
);

  localparam int TW = (RD_TIMEOUT < 1) ? 1 : $clog2(RD_TIMEOUT + 1);
  localparam logic [WIDTH-1:0] CMD_WR = WIDTH'(8'hAA);
  localparam logic [WIDTH-1:0] CMD_RD = WIDTH'(8'hBB);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    RD_ADDR = 3'd3,
    RD_WAIT = 3'd4,
    TX_SEND = 3'd5
  } state_t;

  state_t         state;
  logic [TW-1:0]  tmo_cnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      Address   <= '0;
      WrData    <= '0;
      TX_P_DATA <= '0;
      tmo_cnt   <= '0;
      WrEn      <= 1'b0;
      RdEn      <= 1'b0;
      TX_D_VLD  <= 1'b0;
      BUSY      <= 1'b0;
      CMD_ERR   <= 1'b0;
    end else begin
      // strobes default low so each is a single-cycle pulse
      WrEn     <= 1'b0;
      RdEn     <= 1'b0;
      TX_D_VLD <= 1'b0;
      CMD_ERR  <= 1'b0;
      case (state)
        IDLE: begin
          if (RX_D_VLD) begin
            if (RX_P_DATA == CMD_WR) begin
              state <= WR_ADDR;
              BUSY  <= 1'b1;
            end else if (RX_P_DATA == CMD_RD) begin
              state <= RD_ADDR;
              BUSY  <= 1'b1;
            end else begin
              CMD_ERR <= 1'b1;
            end
          end
        end
        WR_ADDR: begin
          if (RX_D_VLD) begin
            Address <= RX_P_DATA[ADDR-1:0];
            state   <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (RX_D_VLD) begin
            WrData <= RX_P_DATA;
            WrEn   <= 1'b1;
            state  <= IDLE;
            BUSY   <= 1'b0;
          end
        end
        RD_ADDR: begin
          if (RX_D_VLD) begin
            Address <= RX_P_DATA[ADDR-1:0];
            RdEn    <= 1'b1;
            tmo_cnt <= TW'(RD_TIMEOUT);
            state   <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          // stray bytes are dropped; read data wins over the timeout
          if (RX_D_VLD) CMD_ERR <= 1'b1;
          if (RdData_VLD) begin
            TX_P_DATA <= RdData;
            tmo_cnt   <= '0;
            state     <= TX_SEND;
          end else if (tmo_cnt <= TW'(1)) begin
            // counter reaching 0: RD_TIMEOUT cycles spent in RD_WAIT
            tmo_cnt <= '0;
            CMD_ERR <= 1'b1;
            state   <= IDLE;
            BUSY    <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt - TW'(1);
          end
        end
        TX_SEND: begin
          if (RX_D_VLD) CMD_ERR <= 1'b1;
          if (!FIFO_FULL) begin
            TX_D_VLD <= 1'b1;
            state    <= IDLE;
            BUSY     <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// Directed bench for reg_cmd_ctrl. Inputs change and outputs are sampled
// on the falling edge of CLK.
module tb_reg_cmd_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] RX_P_DATA = '0;
  logic       RX_D_VLD = 1'b0;
  logic [3:0] Address;
  logic [7:0] WrData;
  logic       WrEn;
  logic       RdEn;
  logic [7:0] RdData = '0;
  logic       RdData_VLD = 1'b0;
  logic       FIFO_FULL = 1'b0;
  logic [7:0] TX_P_DATA;
  logic       TX_D_VLD;
  logic       BUSY;
  logic       CMD_ERR;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0, rd_cnt = 0, tx_cnt = 0, both_cnt = 0;
  int wr0, rd0, tx0;

  reg_cmd_ctrl #(.WIDTH(8), .ADDR(4), .RD_TIMEOUT(4)) dut (
    .CLK(CLK), .RST(RST),
    .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .Address(Address), .WrData(WrData), .WrEn(WrEn), .RdEn(RdEn),
    .RdData(RdData), .RdData_VLD(RdData_VLD),
    .FIFO_FULL(FIFO_FULL),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
    .BUSY(BUSY), .CMD_ERR(CMD_ERR)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (WrEn) wr_cnt++;
    if (RdEn) rd_cnt++;
    if (TX_D_VLD) tx_cnt++;
    if (WrEn && RdEn) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // drive one cycle of RX input, then land on the next falling edge
  task automatic step(input logic vld, input logic [7:0] d);
    RX_D_VLD  = vld;
    RX_P_DATA = d;
    @(negedge CLK);
    RX_D_VLD  = 1'b0;
  endtask

  task automatic snap();
    wr0 = wr_cnt; rd0 = rd_cnt; tx0 = tx_cnt;
  endtask

  initial begin
    // reset state
    @(negedge CLK); @(negedge CLK);
    chk("rst_busy", BUSY, 0);
    chk("rst_addr", Address, 0);
    chk("rst_wrdata", WrData, 0);
    chk("rst_txdata", TX_P_DATA, 0);
    chk("rst_strobes", {WrEn, RdEn, TX_D_VLD, CMD_ERR}, 0);
    RST = 1'b1;
    step(0, 8'h00);

    // write AA 05 3C, bytes back to back
    snap();
    step(1, 8'hAA); chk("wr_busy_a", BUSY, 1);
    step(1, 8'h05); chk("wr_addr", Address, 5); chk("wr_busy_b", BUSY, 1);
    chk("wr_no_early", WrEn, 0);
    step(1, 8'h3C);
    chk("wr_en", WrEn, 1); chk("wr_data", WrData, 8'h3C);
    chk("wr_addr_hold", Address, 5); chk("wr_busy_done", BUSY, 0);
    step(0, 8'h00);
    chk("wr_en_pulse", WrEn, 0); chk("wr_data_hold", WrData, 8'h3C);
    step(0, 8'h00);
    chk("wr_count", wr_cnt - wr0, 1); chk("wr_no_rd", rd_cnt - rd0, 0);

    // read BB 02, RdData 81 valid one cycle after RdEn
    snap();
    step(1, 8'hBB);
    step(1, 8'h02); chk("rd_en", RdEn, 1); chk("rd_addr", Address, 2);
    step(0, 8'h00); chk("rd_en_pulse", RdEn, 0); chk("rd_wait_busy", BUSY, 1);
    RdData = 8'h81; RdData_VLD = 1'b1;
    step(0, 8'h00);
    RdData_VLD = 1'b0; RdData = 8'h00;
    chk("rd_txdata", TX_P_DATA, 8'h81);
    step(0, 8'h00);
    chk("rd_txvld", TX_D_VLD, 1); chk("rd_tx_data_out", TX_P_DATA, 8'h81);
    chk("rd_idle", BUSY, 0);
    step(0, 8'h00); chk("rd_txvld_pulse", TX_D_VLD, 0);
    step(0, 8'h00);
    chk("rd_count", rd_cnt - rd0, 1); chk("tx_count", tx_cnt - tx0, 1);
    chk("rd_no_wr", wr_cnt - wr0, 0);

    // back-pressure: FIFO full for 5 cycles in TX_SEND, stray byte dropped
    snap();
    FIFO_FULL = 1'b1;
    step(1, 8'hBB);
    step(1, 8'h04); chk("bp_rden", RdEn, 1);
    step(0, 8'h00);
    RdData = 8'h5A; RdData_VLD = 1'b1;
    step(0, 8'h00);
    RdData_VLD = 1'b0; RdData = 8'h00;
    for (int i = 0; i < 5; i++) begin
      step(i == 2, 8'h99);
      chk("bp_no_tx", TX_D_VLD, 0);
      chk("bp_hold_data", TX_P_DATA, 8'h5A);
      chk("bp_busy", BUSY, 1);
      chk("bp_err", CMD_ERR, (i == 2) ? 1 : 0);
    end
    FIFO_FULL = 1'b0;
    step(0, 8'h00);
    chk("bp_tx", TX_D_VLD, 1); chk("bp_tx_data", TX_P_DATA, 8'h5A);
    step(0, 8'h00); chk("bp_tx_pulse", TX_D_VLD, 0); chk("bp_idle", BUSY, 0);
    step(0, 8'h00);
    chk("bp_tx_count", tx_cnt - tx0, 1);

    // unknown command byte
    snap();
    step(1, 8'h55);
    chk("bad_cmd_err", CMD_ERR, 1); chk("bad_cmd_busy", BUSY, 0);
    step(0, 8'h00); chk("bad_cmd_pulse", CMD_ERR, 0);
    step(0, 8'h00);
    chk("bad_cmd_nostrobe", (wr_cnt - wr0) + (rd_cnt - rd0) + (tx_cnt - tx0), 0);

    // read timeout: RdData_VLD never comes; stray byte in RD_WAIT dropped
    snap();
    step(1, 8'hBB);
    step(1, 8'h03); chk("to_rden", RdEn, 1);
    step(1, 8'h77); chk("to_stray_err", CMD_ERR, 1); chk("to_stray_busy", BUSY, 1);
    step(0, 8'h00); chk("to_wait_a", CMD_ERR, 0);
    step(0, 8'h00); chk("to_wait_b", CMD_ERR, 0); chk("to_busy", BUSY, 1);
    step(0, 8'h00); chk("to_err", CMD_ERR, 1); chk("to_idle", BUSY, 0);
    step(0, 8'h00); chk("to_err_pulse", CMD_ERR, 0);
    chk("to_no_tx", tx_cnt - tx0, 0);

    // address truncation
    snap();
    step(1, 8'hAA);
    step(1, 8'hF7);
    step(1, 8'h11);
    chk("tr_wren", WrEn, 1); chk("tr_addr", Address, 7); chk("tr_data", WrData, 8'h11);
    step(0, 8'h00);

    // reset in the middle of a write
    snap();
    step(1, 8'hAA);
    step(1, 8'h03); chk("rm_addr", Address, 3); chk("rm_busy", BUSY, 1);
    RST = 1'b0;
    #1;
    chk("rm_async_busy", BUSY, 0); chk("rm_async_addr", Address, 0);
    chk("rm_async_wrdata", WrData, 0);
    @(negedge CLK);
    RST = 1'b1;
    step(1, 8'h11);
    chk("rm_cmd_err", CMD_ERR, 1); chk("rm_no_wren", WrEn, 0); chk("rm_idle", BUSY, 0);
    step(0, 8'h00);
    step(0, 8'h00);
    chk("rm_wr_count", wr_cnt - wr0, 0);

    chk("wr_rd_exclusive", both_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete, time %0t", $time);
    $fatal(1);
  end

endmodule
